scan_ctrl: RTL and testbench
============================

SCAN_CTRL -- requirements
Module: scan_ctrl

Interface
REQ-001 Parameter COLS, default 64: columns per line; col counts 0..COLS-1.
REQ-002 Parameter ROWS, default 32: scan rows (1/32 scan; two half-panels are driven in parallel).
REQ-003 Parameter PLANES, default 4: BCM colour bit planes per channel.
REQ-004 Parameter HOLD_BASE, default 64: HOLD cycles for plane 0.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst  in  1  asynchronous reset, active-low (0 = reset).
REQ-007 en  in  1  run enable; sampled only in IDLE.
REQ-008 swap_req  in  1  request to flip the read bank; held high until swap_ack.
REQ-009 swap_ack  out  1  one-cycle pulse confirming the bank flip.
REQ-010 mem_addr  out  12  framebuffer read address {bank, row[4:0], col[5:0]}.
REQ-011 mem_data  in  24  {r1,g1,b1,r2,g2,b2}, 4 bits each; valid 1 cycle after mem_addr.
REQ-012 col  out  6  column code for the latch/OE stage.
REQ-013 row_addr  out  5  panel row address A..E.
REQ-014 rgb1 / rgb2  out  3 each  top/bottom pixel bits of the current plane.
REQ-015 frame_start  out  1  one-cycle pulse at the first SHIFT cycle of row 0, plane 0.

Function
REQ-016 FSM states: IDLE, PREFETCH, SHIFT, HOLD.
REQ-017 IDLE -> PREFETCH when en=1; PREFETCH lasts exactly 1 cycle and drives mem_addr for col 0.
REQ-018 SHIFT: COLS cycles; col = 0..63 in order; mem_addr always leads col by 1 cycle, so rgb bits and col are aligned in the same cycle.
REQ-019 rgb1 = {r1[plane], g1[plane], b1[plane]}; rgb2 is formed the same way from r2/g2/b2.
REQ-020 SHIFT at col=63 -> HOLD; HOLD lasts HOLD_BASE << plane cycles (64, 128, 256, 512); the hold counter is 16 bits wide.
REQ-021 During HOLD: col = 1 (neither line-start nor line-end code, so the display stays enabled), rgb = 0.
REQ-022 Last HOLD cycle: mem_addr is set for col 0 of the next pass; the next state is SHIFT (no PREFETCH).
REQ-023 Pass order: plane 0..PLANES-1 within a row, then row+1; row 31, plane 3 wraps to row 0, plane 0.
REQ-024 row_addr updates in the first SHIFT cycle (col=0) of plane 0 of the new row and holds for all planes of that row.
REQ-025 swap_req is sampled only in the last HOLD cycle of row 31, plane 3: the bank toggles and swap_ack pulses in that same cycle; if the request arrives elsewhere, the flip is deferred to that point.
REQ-026 en=0 never aborts a frame; it is acted on only at the frame wrap, where the FSM goes to IDLE instead of SHIFT.
REQ-027 frame_start and swap_ack never assert in the same cycle.

Reset
REQ-028 While rst=0: state=IDLE, col=0, row_addr=0, plane=0, bank=0, hold counter=0, mem_addr=0, rgb1=rgb2=0, swap_ack=0, frame_start=0.
REQ-029 Reset asserted mid-SHIFT or mid-HOLD takes effect immediately (asynchronous); the next frame after release starts at row 0, plane 0, bank 0.

Structure
REQ-030 A shared package holds COLS, ROWS, PLANES, HOLD_BASE, the FSM state encoding, and the mem_data field offsets.
REQ-031 One sub-module, bcm_hold_timer (load plane, count down, done pulse), is natural; the rest stays flat.

Verification
REQ-032 Reset release with en=1 -> PREFETCH at cycle 1; col=0 at cycle 2; col=63 at cycle 65; frame_start pulses at cycle 2.
REQ-033 mem_data bit 23 (r1) = plane-bit pattern 4'b1010 at col 5 -> rgb1[2] at col 5 reads 0, 1, 0, 1 for planes 0..3.
REQ-034 HOLD length per plane measured -> 64, 128, 256, 512 cycles; row_addr goes 0 -> 1 exactly at col=0 of row 1, plane 0.
REQ-035 swap_req raised at row 10 -> swap_ack pulses only at the last HOLD cycle of row 31, plane 3; mem_addr[11] = 1 from the next SHIFT on.
REQ-036 Reset pulled low at row 7, plane 2, col 40 -> all outputs equal reset values in that cycle; after release, row_addr=0 and frame_start pulses again.
REQ-037 en dropped at row 3 -> the frame completes through row 31, plane 3, then the FSM holds in IDLE with col=0.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared constants for the LED matrix scan controller.
// Holds default geometry, BCM timing base, FSM encoding, framebuffer word layout
// and a helper that picks one bit plane out of three colour nibbles.
package scan_ctrl_pkg;

  localparam int DEF_COLS      = 64;
  localparam int DEF_ROWS      = 32;
  localparam int DEF_PLANES    = 4;
  localparam int DEF_HOLD_BASE = 64;

  localparam int COL_W   = 6;
  localparam int ROW_W   = 5;
  localparam int PLANE_W = 2;
  localparam int HOLD_W  = 16;
  localparam int ADDR_W  = 1 + ROW_W + COL_W;   // {bank, row, col}
  localparam int DATA_W  = 24;
  localparam int BPC     = 4;                   // bits per colour channel

  // mem_data = {r1, g1, b1, r2, g2, b2}
  localparam int R1_OFS = 20;
  localparam int G1_OFS = 16;
  localparam int B1_OFS = 12;
  localparam int R2_OFS = 8;
  localparam int G2_OFS = 4;
  localparam int B2_OFS = 0;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREFETCH = 2'd1,
    SHIFT    = 2'd2,
    HOLD     = 2'd3
  } state_t;

  function automatic logic [2:0] plane_bits(input logic [BPC-1:0] r,
                                            input logic [BPC-1:0] g,
                                            input logic [BPC-1:0] b,
                                            input logic [PLANE_W-1:0] p);
    return {r[p], g[p], b[p]};
  endfunction

endpackage

// File: rtl/scan_ctrl_if.sv
// Bundle of the scan controller's control, framebuffer and panel-drive signals.
// master: controller side (drives swap_ack, mem_addr, col, row_addr, rgb1/2, frame_start).
// slave : environment side (drives en, swap_req, mem_data).
interface scan_ctrl_if
  import scan_ctrl_pkg::*;
();
  logic              en;
  logic              swap_req;
  logic              swap_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row_addr;
  logic [2:0]        rgb1;
  logic [2:0]        rgb2;
  logic              frame_start;

  modport master (
    input  en, swap_req, mem_data,
    output swap_ack, mem_addr, col, row_addr, rgb1, rgb2, frame_start
  );

  modport slave (
    output en, swap_req, mem_data,
    input  swap_ack, mem_addr, col, row_addr, rgb1, rgb2, frame_start
  );
endinterface

// File: rtl/bcm_hold_timer.sv
// Binary-code-modulation hold timer: load with the current plane, count down, flag the last cycle.
// Ports: clk, rst (async active-low), load (start a hold), plane (selects HOLD_BASE << plane),
// done (high during the final hold cycle only).
module bcm_hold_timer
  import scan_ctrl_pkg::*;
#(
  parameter int HOLD_BASE = DEF_HOLD_BASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [PLANE_W-1:0] plane,
  output logic               done
);

  localparam logic [HOLD_W-1:0] BASE = HOLD_W'(HOLD_BASE);

  logic [HOLD_W-1:0] cnt;
  logic              run;

  // Loaded with length-1 so that done marks the last of (HOLD_BASE << plane) cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      run <= 1'b0;
    end else if (load) begin
      cnt <= (BASE << plane) - 1'b1;
      run <= 1'b1;
    end else if (run) begin
      if (cnt == '0) begin
        run <= 1'b0;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign done = run && (cnt == '0);

endmodule

// File: rtl/scan_ctrl.sv
// HUB75-style scan controller: walks rows x BCM planes, shifting one line per pass then holding.
// Ports: clk, rst (async active-low), bus (scan_ctrl_if.master: en/swap handshake,
// framebuffer read port with 1-cycle latency, panel column/row/pixel outputs, frame_start).
module scan_ctrl
  import scan_ctrl_pkg::*;
#(
  parameter int COLS      = DEF_COLS,
  parameter int ROWS      = DEF_ROWS,
  parameter int PLANES    = DEF_PLANES,
  parameter int HOLD_BASE = DEF_HOLD_BASE
) (
  input logic        clk,
  input logic        rst,
  scan_ctrl_if.master bus
);

  localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
  localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(PLANES - 1);

  state_t             state, state_nxt;
  logic [COL_W-1:0]   col_cnt, col_inc;
  logic [ROW_W-1:0]   row, row_nxt;
  logic [PLANE_W-1:0] plane, plane_nxt;
  logic               bank;
  logic               hold_load, hold_done, hold_last;
  logic               last_col, last_plane, last_row, frame_end, swap_now;
  logic [ADDR_W-1:0]  addr_c;

  bcm_hold_timer #(.HOLD_BASE(HOLD_BASE)) u_hold (
    .clk   (clk),
    .rst   (rst),
    .load  (hold_load),
    .plane (plane),
    .done  (hold_done)
  );

  assign last_col   = (col_cnt == COL_LAST);
  assign last_plane = (plane == PLANE_LAST);
  assign last_row   = (row == ROW_LAST);
  assign frame_end  = last_row && last_plane;
  assign hold_last  = (state == HOLD) && hold_done;
  // Bank flips only at the very end of a frame so a frame is never torn.
  assign swap_now   = hold_last && frame_end && bus.swap_req;

  assign col_inc   = last_col ? '0 : col_cnt + 1'b1;
  assign plane_nxt = last_plane ? '0 : plane + 1'b1;
  assign row_nxt   = !last_plane ? row : (last_row ? '0 : row + 1'b1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_load = 1'b0;
    case (state)
      IDLE:     if (bus.en) state_nxt = PREFETCH;
      PREFETCH: state_nxt = SHIFT;
      SHIFT: begin
        if (last_col) begin
          state_nxt = HOLD;
          hold_load = 1'b1;
        end
      end
      HOLD: begin
        // en is only honoured at the frame wrap; mid-frame it is ignored.
        if (hold_done) state_nxt = (frame_end && !bus.en) ? IDLE : SHIFT;
      end
      default:  state_nxt = IDLE;
    endcase
  end

  // row/plane advance at the end of each hold so the next pass (and row_addr)
  // switch together at its first SHIFT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_cnt <= '0;
      row     <= '0;
      plane   <= '0;
      bank    <= 1'b0;
    end else begin
      if (state == SHIFT) col_cnt <= col_inc;
      if (hold_last) begin
        row   <= row_nxt;
        plane <= plane_nxt;
      end
      if (swap_now) bank <= ~bank;
    end
  end

  // Read address runs one column ahead of col to absorb the memory latency.
  always_comb begin
    addr_c = '0;
    case (state)
      PREFETCH: addr_c = {bank, row, {COL_W{1'b0}}};
      SHIFT:    addr_c = {bank, row, col_inc};
      HOLD: begin
        if (hold_done) addr_c = {bank ^ swap_now, row_nxt, {COL_W{1'b0}}};
        else           addr_c = {bank, row, {COL_W{1'b0}}};
      end
      default:  addr_c = '0;
    endcase
  end

  assign bus.mem_addr    = addr_c;
  assign bus.row_addr    = row;
  assign bus.swap_ack    = swap_now;
  // Column code 1 during hold keeps the latch/OE stage enabled.
  assign bus.col         = (state == SHIFT) ? col_cnt :
                           (state == HOLD)  ? COL_W'(1) : '0;
  assign bus.frame_start = (state == SHIFT) && (col_cnt == '0) && (row == '0) && (plane == '0);
  assign bus.rgb1        = (state == SHIFT) ?
                           plane_bits(bus.mem_data[R1_OFS +: BPC], bus.mem_data[G1_OFS +: BPC],
                                      bus.mem_data[B1_OFS +: BPC], plane) : 3'b000;
  assign bus.rgb2        = (state == SHIFT) ?
                           plane_bits(bus.mem_data[R2_OFS +: BPC], bus.mem_data[G2_OFS +: BPC],
                                      bus.mem_data[B2_OFS +: BPC], plane) : 3'b000;

endmodule

// File: tb/tb_scan_ctrl.sv
// Bench for scan_ctrl: framebuffer model with 1-cycle read latency, frame-level reference
// model feeding a per-cycle expectation queue, and a negedge monitor comparing outputs.
module tb_scan_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scan_ctrl_if bus();

  scan_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [23:0] fb [4096];
  always @(posedge clk) bus.mem_data <= fb[bus.mem_addr];

  typedef struct {
    logic [5:0]  col;
    logic [4:0]  row;
    logic [2:0]  rgb1;
    logic [2:0]  rgb2;
    logic        fs;
    logic        sa;
    logic [11:0] addr;
    bit          care;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  function automatic logic [11:0] mk_addr(input int bank, input int r, input int c);
    return 12'(((bank & 1) << 11) | ((r & 31) << 6) | (c & 63));
  endfunction

  function automatic logic [2:0] pix(input logic [23:0] d, input logic [1:0] p, input bit top);
    logic [3:0] r, g, b;
    if (top) begin r = d[23:20]; g = d[19:16]; b = d[15:12]; end
    else     begin r = d[11:8];  g = d[7:4];   b = d[3:0];   end
    return {r[p], g[p], b[p]};
  endfunction

  task automatic push(input int c, input int r, input logic [2:0] p1, input logic [2:0] p2,
                      input bit fs, input bit sa, input logic [11:0] a, input bit care);
    exp_t e;
    e.col = 6'(c); e.row = 5'(r); e.rgb1 = p1; e.rgb2 = p2;
    e.fs = fs; e.sa = sa; e.addr = a; e.care = care;
    exp_q.push_back(e);
  endtask

  // Whole-frame expectation: one IDLE cycle, PREFETCH, then for each row/plane a
  // 64-column shift followed by a (64 << plane)-cycle hold.
  task automatic push_frame(input int bank, input bit swap, input bit to_idle, input int nrows);
    int hl, nr, nb;
    bit fe;
    logic [23:0] d;
    push(0, 0, 3'b0, 3'b0, 0, 0, 12'h0, 0);
    push(0, 0, 3'b0, 3'b0, 0, 0, mk_addr(bank, 0, 0), 1);
    for (int r = 0; r < nrows; r++) begin
      for (int p = 0; p < 4; p++) begin
        for (int c = 0; c < 64; c++) begin
          d = fb[mk_addr(bank, r, c)];
          push(c, r, pix(d, 2'(p), 1), pix(d, 2'(p), 0), (r == 0 && p == 0 && c == 0), 0,
               mk_addr(bank, r, c + 1), c < 63);
        end
        hl = 64 << p;
        fe = (r == 31 && p == 3);
        nr = (p == 3) ? (r + 1) % 32 : r;
        nb = (fe && swap) ? bank ^ 1 : bank;
        for (int h = 0; h < hl; h++)
          push(1, r, 3'b0, 3'b0, 0, (h == hl - 1) && fe && swap, mk_addr(nb, nr, 0), h == hl - 1);
      end
    end
    if (to_idle)
      for (int i = 0; i < 20; i++) push(0, 0, 3'b0, 3'b0, 0, 0, 12'h0, 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.col !== e.col || bus.row_addr !== e.row || bus.rgb1 !== e.rgb1 ||
          bus.rgb2 !== e.rgb2 || bus.frame_start !== e.fs || bus.swap_ack !== e.sa ||
          (e.care && bus.mem_addr !== e.addr)) begin
        errors++;
        $display("FAIL trace@%0t: got col=%0d row=%0d rgb1=%b rgb2=%b fs=%b ack=%b addr=%h; want col=%0d row=%0d rgb1=%b rgb2=%b fs=%b ack=%b addr=%h(care=%0d)",
                 $time, bus.col, bus.row_addr, bus.rgb1, bus.rgb2, bus.frame_start, bus.swap_ack,
                 bus.mem_addr, e.col, e.row, e.rgb1, e.rgb2, e.fs, e.sa, e.addr, e.care);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_col"},   32'(bus.col), 0);
    chk({tag, "_row"},   32'(bus.row_addr), 0);
    chk({tag, "_rgb1"},  32'(bus.rgb1), 0);
    chk({tag, "_rgb2"},  32'(bus.rgb2), 0);
    chk({tag, "_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_ack"},   32'(bus.swap_ack), 0);
    chk({tag, "_fs"},    32'(bus.frame_start), 0);
  endtask

  task automatic wait_row(input logic [4:0] v);
    int n;
    n = 0;
    while (bus.row_addr !== v && n < 60000) begin
      @(posedge clk); #1; n++;
    end
    chk("wait_row", 32'(bus.row_addr), 32'(v));
  endtask

  task automatic wait_ack();
    int n;
    n = 0;
    while (bus.swap_ack !== 1'b1 && n < 60000) begin
      @(negedge clk); n++;
    end
    chk("swap_ack_seen", 32'(bus.swap_ack), 1);
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 60000) begin
      @(posedge clk); n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b0;
    bus.en = 1'b1;
    bus.swap_req = 1'b0;
    for (int i = 0; i < 4096; i++) fb[i] = 24'($urandom);
    // Row 0, col 5, bank 0: r1 nibble 1010 -> planes 0..3 give 0,1,0,1 on rgb1[2].
    fb[5] = (fb[5] & 24'h0FFFFF) | 24'hA00000;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");

    // Frame 1: en drops at row 3, swap requested at row 10; frame completes then idles.
    @(posedge clk); #1;
    rst = 1'b1;
    push_frame(0, 1, 1, 32);
    wait_row(5'd3);
    bus.en = 1'b0;
    wait_row(5'd10);
    bus.swap_req = 1'b1;
    wait_ack();
    @(posedge clk); #1;
    bus.swap_req = 1'b0;
    wait_empty("frame1_drain");

    // Frame 2 from bank 1; reset hits at row 7, plane 2, col 40 (cycle 8874 from IDLE).
    #1;
    bus.en = 1'b1;
    push_frame(1, 0, 0, 8);
    repeat (8874) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk_reset_outputs("midreset");

    // Restart after release: row 0, plane 0, bank 0, frame_start again.
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    push_frame(0, 0, 0, 1);
    wait_empty("frame3_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 90000) begin
      $display("FAIL timeout: cycle %0d, limit 90000", cyc);
      $fatal(1, "timeout");
    end
  end

endmodule
